mdu_alu: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle datapath ALU. It keeps the eight arithmetic, logic and compare operations and adds:
- signed overflow detection;
- iterative signed/unsigned multiply and divide into HI/LO registers;
- HI/LO move-out operations;
- a start/busy/done handshake so the MIPS control unit can stall on long operations.

It sits in the EX stage in place of the combinational ALU.

---
 rtl/mdu_alu_if.sv | 28 ++
 rtl/mdu_alu.sv | 205 ++++++++++++++++++++
 tb/tb_mdu_alu.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_alu_if.sv
// Request/response bundle for the multi-cycle multiply/divide ALU.
// The master issues start/op/operands; the slave returns registered results and status.
interface mdu_alu_if #(
    parameter int unsigned W = 32
);
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Y;
    logic         Z;
    logic         V;
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    modport master (
        output start, op, A, B,
        input  Y, Z, V, dz, hi, lo, busy, done
    );

    modport slave (
        input  start, op, A, B,
        output Y, Z, V, dz, hi, lo, busy, done
    );
endinterface

// File: rtl/mdu_alu.sv
// EX-stage ALU: single-cycle arithmetic/logic/compare plus iterative signed/unsigned
// multiply and restoring divide into HI/LO, with a start/busy/done handshake.
module mdu_alu #(
    parameter int unsigned W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mdu_alu_if.slave   bus
);
    localparam int unsigned CW = $clog2(W) + 1;

    localparam logic [3:0] OpAdd   = 4'b0000;
    localparam logic [3:0] OpSub   = 4'b0001;
    localparam logic [3:0] OpAnd   = 4'b0010;
    localparam logic [3:0] OpOr    = 4'b0011;
    localparam logic [3:0] OpXor   = 4'b0100;
    localparam logic [3:0] OpNor   = 4'b0101;
    localparam logic [3:0] OpSlt   = 4'b0110;
    localparam logic [3:0] OpSltu  = 4'b0111;
    localparam logic [3:0] OpMult  = 4'b1000;
    localparam logic [3:0] OpMultu = 4'b1001;
    localparam logic [3:0] OpDiv   = 4'b1010;
    localparam logic [3:0] OpDivu  = 4'b1011;
    localparam logic [3:0] OpMfhi  = 4'b1100;
    localparam logic [3:0] OpMflo  = 4'b1101;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2*W-1:0]   work_q, work_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic [W-1:0]     y_q, y_d, hi_q, hi_d, lo_q, lo_d;
    logic             z_q, z_d, v_q, v_d, dz_q, dz_d, done_q, done_d;

    logic [W:0]       mul_sum, mul_hi, rem_sh, div_diff;
    logic [2*W-1:0]   step_work, prod;
    logic [W-1:0]     quo, rem, fin_hi, fin_lo;
    logic [W-1:0]     sum_ab, diff_ab, mag_a, mag_b;
    logic             sgn, launch;

    // One iteration: work holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, work_q[2*W-1:W]} + {1'b0, opnd_q};
        mul_hi   = work_q[0] ? mul_sum : {1'b0, work_q[2*W-1:W]};
        rem_sh   = {work_q[2*W-1:W], work_q[W-1]};
        div_diff = rem_sh - {1'b0, opnd_q};
        if (is_div_q) begin
            step_work = div_diff[W] ? {rem_sh[W-1:0], work_q[W-2:0], 1'b0}
                                    : {div_diff[W-1:0], work_q[W-2:0], 1'b1};
        end else begin
            step_work = {mul_hi, work_q[W-1:1]};
        end
        prod = neg_q ? -step_work : step_work;
        quo  = neg_q ? -step_work[W-1:0] : step_work[W-1:0];
        rem  = rneg_q ? -step_work[2*W-1:W] : step_work[2*W-1:W];
        fin_hi = is_div_q ? rem : prod[2*W-1:W];
        fin_lo = is_div_q ? quo : prod[W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        y_d      = y_q;
        z_d      = z_q;
        v_d      = v_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        launch   = 1'b0;
        sum_ab   = bus.A + bus.B;
        diff_ab  = bus.A - bus.B;
        sgn      = ~bus.op[0];
        mag_a    = (sgn && bus.A[W-1]) ? -bus.A : bus.A;
        mag_b    = (sgn && bus.B[W-1]) ? -bus.B : bus.B;

        if (state_q == StIdle) begin
            if (bus.start) begin
                done_d = 1'b1;
                v_d    = 1'b0;
                dz_d   = 1'b0;
                y_d    = '0;
                case (bus.op)
                    OpAdd: begin
                        y_d = sum_ab;
                        v_d = (bus.A[W-1] == bus.B[W-1]) && (sum_ab[W-1] != bus.A[W-1]);
                    end
                    OpSub: begin
                        y_d = diff_ab;
                        v_d = (bus.A[W-1] != bus.B[W-1]) && (diff_ab[W-1] != bus.A[W-1]);
                    end
                    OpAnd:  y_d = bus.A & bus.B;
                    OpOr:   y_d = bus.A | bus.B;
                    OpXor:  y_d = bus.A ^ bus.B;
                    OpNor:  y_d = ~(bus.A | bus.B);
                    OpSlt:  y_d = {{(W-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
                    OpSltu: y_d = {{(W-1){1'b0}}, bus.A < bus.B};
                    OpMult, OpMultu: begin
                        launch   = 1'b1;
                        work_d   = {{W{1'b0}}, mag_b};
                        opnd_d   = mag_a;
                        is_div_d = 1'b0;
                        neg_d    = sgn && (bus.A[W-1] ^ bus.B[W-1]);
                        rneg_d   = 1'b0;
                    end
                    OpDiv, OpDivu: begin
                        if (bus.B == '0) begin
                            // No iteration: fixed result, completes like a 1-cycle op.
                            dz_d = 1'b1;
                            y_d  = '1;
                            lo_d = '1;
                            hi_d = bus.A;
                        end else begin
                            launch   = 1'b1;
                            work_d   = {{W{1'b0}}, mag_a};
                            opnd_d   = mag_b;
                            is_div_d = 1'b1;
                            neg_d    = sgn && (bus.A[W-1] ^ bus.B[W-1]);
                            rneg_d   = sgn && bus.A[W-1];
                        end
                    end
                    OpMfhi:  y_d = hi_q;
                    OpMflo:  y_d = lo_q;
                    default: y_d = '0;
                endcase
                if (launch) begin
                    state_d = StRun;
                    count_d = CW'(W);
                    done_d  = 1'b0;
                    y_d     = y_q;
                    v_d     = v_q;
                    dz_d    = dz_q;
                    z_d     = z_q;
                end else begin
                    z_d = (y_d == '0);
                end
            end
        end else begin
            work_d  = step_work;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
                state_d = StIdle;
                done_d  = 1'b1;
                hi_d    = fin_hi;
                lo_d    = fin_lo;
                y_d     = fin_lo;
                z_d     = (fin_lo == '0);
                v_d     = 1'b0;
                dz_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            y_q      <= '0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            y_q      <= y_d;
            z_q      <= z_d;
            v_q      <= v_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.Y    = y_q;
    assign bus.Z    = z_q;
    assign bus.V    = v_q;
    assign bus.dz   = dz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q == StRun);
    assign bus.done = done_q;
endmodule

// File: tb/tb_mdu_alu.sv
// Self-checking bench for mdu_alu: directed corner cases, random ops against a
// plain-arithmetic reference model, reset abort, and a W=8 instance.
module tb_mdu_alu;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_alu_if #(.W(32)) bus32 ();
    mdu_alu_if #(.W(8))  bus8 ();

    mdu_alu #(.W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
    mdu_alu #(.W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference model from the arithmetic definition of each op.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ey, output logic ev, output logic edz,
                         output logic [31:0] ehi, output logic [31:0] elo, output int elat);
        longint      sa, sb, s, q, r;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ey = '0; ev = 1'b0; edz = 1'b0; ehi = m_hi; elo = m_lo; elat = 0;
        case (o)
            4'd0: begin s = sa + sb; ey = a + b;
                ev = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd1: begin s = sa - sb; ey = a - b;
                ev = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd2: ey = a & b;
            4'd3: ey = a | b;
            4'd4: ey = a ^ b;
            4'd5: ey = ~(a | b);
            4'd6: ey = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: ey = (a < b) ? 32'd1 : 32'd0;
            4'd8: begin s = sa * sb; ehi = s[63:32]; elo = s[31:0]; ey = elo; elat = 32; end
            4'd9: begin pu = {32'b0, a} * {32'b0, b}; ehi = pu[63:32]; elo = pu[31:0];
                ey = elo; elat = 32; end
            4'd10, 4'd11: begin
                if (b == 32'd0) begin
                    edz = 1'b1; elo = '1; ehi = a; ey = '1;
                end else begin
                    if (o == 4'd10) begin q = sa / sb; r = sa % sb; end
                    else begin q = longint'(a / b); r = longint'(a % b); end
                    elo = q[31:0]; ehi = r[31:0]; ey = elo; elat = 32;
                end
            end
            4'd12: ey = m_hi;
            4'd13: ey = m_lo;
            default: ey = '0;
        endcase
    endtask

    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int k, output int bc);
        @(negedge clk);
        bus32.start = 1'b1; bus32.op = o; bus32.A = a; bus32.B = b;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        bus32.op = 4'($urandom); bus32.A = $urandom; bus32.B = $urandom;
        k = 0; bc = 0;
        while (!bus32.done && k < 100) begin
            if (bus32.busy) bc++;
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic exec(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
        logic [31:0] ey, ehi, elo;
        logic        ev, edz;
        int          elat, k, bc;
        model(o, a, b, ey, ev, edz, ehi, elo, elat);
        do_op(o, a, b, k, bc);
        check({tag, "_lat"}, k, elat);
        check({tag, "_busycyc"}, bc, elat);
        check({tag, "_y"}, bus32.Y, ey);
        check({tag, "_z"}, {31'b0, bus32.Z}, {31'b0, ey == 32'd0});
        check({tag, "_v"}, {31'b0, bus32.V}, {31'b0, ev});
        check({tag, "_dz"}, {31'b0, bus32.dz}, {31'b0, edz});
        check({tag, "_hi"}, bus32.hi, ehi);
        check({tag, "_lo"}, bus32.lo, elo);
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ta, tb_v;
        logic [3:0]  ro;
        int          ndone, first, k, bc, dn;

        rst_n = 1'b0;
        bus32.start = 1'b0; bus32.op = '0; bus32.A = '0; bus32.B = '0;
        bus8.start = 1'b0;  bus8.op = '0;  bus8.A = '0;  bus8.B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", bus32.Y, 32'd0);
        check("rst_z", {31'b0, bus32.Z}, 32'd0);
        check("rst_v", {31'b0, bus32.V}, 32'd0);
        check("rst_dz", {31'b0, bus32.dz}, 32'd0);
        check("rst_hi", bus32.hi, 32'd0);
        check("rst_lo", bus32.lo, 32'd0);
        check("rst_busy", {31'b0, bus32.busy}, 32'd0);
        check("rst_done", {31'b0, bus32.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        exec(4'd0, 32'h7FFFFFFF, 32'h00000001, "add_ovf");
        check("add_ovf_const_y", bus32.Y, 32'h80000000);
        check("add_ovf_const_v", {31'b0, bus32.V}, 32'd1);
        exec(4'd1, 32'd5, 32'd5, "sub_zero");
        check("sub_zero_const_z", {31'b0, bus32.Z}, 32'd1);
        exec(4'd6, 32'hFFFFFFFF, 32'd1, "slt");
        check("slt_const_y", bus32.Y, 32'd1);
        exec(4'd7, 32'hFFFFFFFF, 32'd1, "sltu");
        check("sltu_const_y", bus32.Y, 32'd0);

        // multu with add requests pulsed during busy; they must be dropped.
        @(negedge clk);
        bus32.start = 1'b1; bus32.op = 4'd9; bus32.A = 32'hFFFFFFFF; bus32.B = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        ndone = 0; first = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus32.start = (c == 5 || c == 12 || c == 20);
            bus32.op = 4'd0; bus32.A = 32'd1; bus32.B = 32'd1;
            @(posedge clk); #1;
            if (bus32.done) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        bus32.start = 1'b0;
        check("multu_ign_ndone", ndone, 1);
        check("multu_ign_lat", first, 32);
        check("multu_ign_hi", bus32.hi, 32'hFFFFFFFE);
        check("multu_ign_lo", bus32.lo, 32'h00000001);
        m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001;

        exec(4'd8, -32'sd3, 32'd5, "mult");
        check("mult_const_hi", bus32.hi, 32'hFFFFFFFF);
        check("mult_const_lo", bus32.lo, 32'hFFFFFFF1);
        exec(4'd12, 32'd0, 32'd0, "mfhi");
        check("mfhi_const_y", bus32.Y, 32'hFFFFFFFF);
        exec(4'd13, 32'd0, 32'd0, "mflo");
        check("mflo_const_y", bus32.Y, 32'hFFFFFFF1);

        exec(4'd10, -32'sd7, 32'd2, "div");
        check("div_const_lo", bus32.lo, 32'hFFFFFFFD);
        check("div_const_hi", bus32.hi, 32'hFFFFFFFF);
        exec(4'd11, 32'd7, 32'd0, "divu_dz");
        check("divu_dz_const_dz", {31'b0, bus32.dz}, 32'd1);
        check("divu_dz_const_hi", bus32.hi, 32'd7);
        exec(4'd10, 32'h80000000, 32'hFFFFFFFF, "div_min");
        check("div_min_const_lo", bus32.lo, 32'h80000000);
        check("div_min_const_hi", bus32.hi, 32'd0);
        exec(4'd14, 32'd9, 32'd9, "reserved");
        check("reserved_const_z", {31'b0, bus32.Z}, 32'd1);

        // Start held high across several single-cycle adds.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ta = $urandom; tb_v = $urandom;
            bus32.start = 1'b1; bus32.op = 4'd0; bus32.A = ta; bus32.B = tb_v;
            @(posedge clk); #1;
            check("b2b_done", {31'b0, bus32.done}, 32'd1);
            check("b2b_y", bus32.Y, ta + tb_v);
        end
        @(negedge clk);
        bus32.start = 1'b0;

        for (int i = 0; i < 30; i++) begin
            ro = 4'($urandom_range(0, 15));
            ta = $urandom;
            tb_v = $urandom;
            if ($urandom_range(0, 3) == 0) tb_v = $urandom_range(0, 3);
            exec(ro, ta, tb_v, "rand");
        end

        // Abort a multiply with reset ten cycles into the run.
        @(negedge clk);
        bus32.start = 1'b1; bus32.op = 4'd9; bus32.A = 32'h12345678; bus32.B = 32'h9ABCDEF0;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstrun_busy", {31'b0, bus32.busy}, 32'd0);
        check("rstrun_hi", bus32.hi, 32'd0);
        check("rstrun_lo", bus32.lo, 32'd0);
        dn = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus32.done) dn++;
        end
        check("rstrun_no_done", dn, 0);
        m_hi = '0; m_lo = '0;
        exec(4'd9, 32'd3, 32'd4, "multu_after_rst");
        check("multu_after_rst_lo", bus32.lo, 32'd12);

        // Narrow instance.
        @(negedge clk);
        bus8.start = 1'b1; bus8.op = 4'd9; bus8.A = 8'hFF; bus8.B = 8'hFF;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        k = 0; bc = 0;
        while (!bus8.done && k < 100) begin
            if (bus8.busy) bc++;
            @(posedge clk); #1;
            k++;
        end
        check("w8_multu_lat", k, 8);
        check("w8_multu_busycyc", bc, 8);
        check("w8_multu_hi", {24'b0, bus8.hi}, 32'h000000FE);
        check("w8_multu_lo", {24'b0, bus8.lo}, 32'h00000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
